// File: rtl/wb_arbiter_1m_2s.sv
// Wishbone 1-master / 2-slave interconnect: m_addr_i[31] selects slave 0 (RAM) or slave 1 (UART).
// Optional cycle watchdog enabled by defining ARB_TIMEOUT_EN.
module wb_arbiter_1m_2s #(
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    // master side
    input  logic [31:0]     m_addr_i,
    input  logic [DW-1:0]   m_data_i,
    output logic [DW-1:0]   m_data_o,
    input  logic [DW/8-1:0] m_sel_i,
    input  logic            m_cyc_i,
    input  logic            m_stb_i,
    input  logic            m_we_i,
    output logic            m_ack_o,
    output logic            m_err_o,
    output logic            m_rty_o,
    // slave 0
    output logic [30:0]     s0_addr_o,
    output logic [DW-1:0]   s0_data_o,
    input  logic [DW-1:0]   s0_data_i,
    output logic [DW/8-1:0] s0_sel_o,
    output logic            s0_cyc_o,
    output logic            s0_stb_o,
    output logic            s0_we_o,
    input  logic            s0_ack_i,
    input  logic            s0_err_i,
    input  logic            s0_rty_i,
    // slave 1
    output logic [30:0]     s1_addr_o,
    output logic [DW-1:0]   s1_data_o,
    input  logic [DW-1:0]   s1_data_i,
    output logic [DW/8-1:0] s1_sel_o,
    output logic            s1_cyc_o,
    output logic            s1_stb_o,
    output logic            s1_we_o,
    input  logic            s1_ack_i,
    input  logic            s1_err_i,
    input  logic            s1_rty_i
);

    logic sel1_s;
    logic req_s;
    logic timeout_s;
    logic sel_ack_s;
    logic sel_err_s;
    logic sel_rty_s;

    assign sel1_s = m_addr_i[31];
    assign req_s  = m_cyc_i & m_stb_i & ~rst_i;

    // Request fields go to both slaves; only cyc/stb qualify the target.
    assign s0_addr_o = m_addr_i[30:0];
    assign s1_addr_o = m_addr_i[30:0];
    assign s0_data_o = m_data_i;
    assign s1_data_o = m_data_i;
    assign s0_sel_o  = m_sel_i;
    assign s1_sel_o  = m_sel_i;
    assign s0_we_o   = m_we_i;
    assign s1_we_o   = m_we_i;

    // Route cyc/stb to the decoded slave and pick its response lines.
    always_comb begin
        s0_cyc_o  = 1'b0;
        s0_stb_o  = 1'b0;
        s1_cyc_o  = 1'b0;
        s1_stb_o  = 1'b0;
        m_data_o  = s0_data_i;
        sel_ack_s = 1'b0;
        sel_err_s = 1'b0;
        sel_rty_s = 1'b0;
        case (sel1_s)
            1'b0: begin
                s0_cyc_o  = m_cyc_i & ~rst_i & ~timeout_s;
                s0_stb_o  = m_stb_i & ~rst_i & ~timeout_s;
                m_data_o  = s0_data_i;
                sel_ack_s = s0_ack_i;
                sel_err_s = s0_err_i;
                sel_rty_s = s0_rty_i;
            end
            1'b1: begin
                s1_cyc_o  = m_cyc_i & ~rst_i & ~timeout_s;
                s1_stb_o  = m_stb_i & ~rst_i & ~timeout_s;
                m_data_o  = s1_data_i;
                sel_ack_s = s1_ack_i;
                sel_err_s = s1_err_i;
                sel_rty_s = s1_rty_i;
            end
            default: begin
                s0_cyc_o  = 1'b0;
                s0_stb_o  = 1'b0;
                s1_cyc_o  = 1'b0;
                s1_stb_o  = 1'b0;
                m_data_o  = s0_data_i;
                sel_ack_s = 1'b0;
                sel_err_s = 1'b0;
                sel_rty_s = 1'b0;
            end
        endcase
    end

    // Responses reach the master only inside an active, non-reset strobe.
    always_comb begin
        m_ack_o = req_s & sel_ack_s;
        m_err_o = (req_s & sel_err_s) | timeout_s;
        m_rty_o = req_s & sel_rty_s;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    assign timeout_s = req_s & (cnt_r == CNT_MAX);

    // Stall counter: counts cycles of an unanswered strobe, restarts after each timeout.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= CNT_ZERO;
        end else if (timeout_s) begin
            cnt_r <= CNT_ZERO;
        end else if (!(m_cyc_i && m_stb_i)) begin
            cnt_r <= CNT_ZERO;
        end else if (sel_ack_s || sel_err_s || sel_rty_s) begin
            cnt_r <= CNT_ZERO;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end
`else
    logic unused_clk_s;

    assign timeout_s    = 1'b0;
    assign unused_clk_s = clk_i;
`endif

endmodule

// File: tb/tb_wb_arbiter_1m_2s.sv
// Directed self-checking bench for wb_arbiter_1m_2s; watchdog scenario runs when ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter_1m_2s;

    localparam int DW = 32;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [31:0]     m_addr_i;
    logic [DW-1:0]   m_data_i;
    logic [DW-1:0]   m_data_o;
    logic [DW/8-1:0] m_sel_i;
    logic            m_cyc_i, m_stb_i, m_we_i;
    logic            m_ack_o, m_err_o, m_rty_o;
    logic [30:0]     s0_addr_o, s1_addr_o;
    logic [DW-1:0]   s0_data_o, s1_data_o, s0_data_i, s1_data_i;
    logic [DW/8-1:0] s0_sel_o, s1_sel_o;
    logic            s0_cyc_o, s0_stb_o, s0_we_o, s1_cyc_o, s1_stb_o, s1_we_o;
    logic            s0_ack_i, s0_err_i, s0_rty_i, s1_ack_i, s1_err_i, s1_rty_i;

    int checks = 0;
    int passed = 0;

    always #5 clk_i = ~clk_i;

    wb_arbiter_1m_2s #(.DW(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m_addr_i(m_addr_i), .m_data_i(m_data_i), .m_data_o(m_data_o), .m_sel_i(m_sel_i),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s0_addr_o(s0_addr_o), .s0_data_o(s0_data_o), .s0_data_i(s0_data_i), .s0_sel_o(s0_sel_o),
        .s0_cyc_o(s0_cyc_o), .s0_stb_o(s0_stb_o), .s0_we_o(s0_we_o),
        .s0_ack_i(s0_ack_i), .s0_err_i(s0_err_i), .s0_rty_i(s0_rty_i),
        .s1_addr_o(s1_addr_o), .s1_data_o(s1_data_o), .s1_data_i(s1_data_i), .s1_sel_o(s1_sel_o),
        .s1_cyc_o(s1_cyc_o), .s1_stb_o(s1_stb_o), .s1_we_o(s1_we_o),
        .s1_ack_i(s1_ack_i), .s1_err_i(s1_err_i), .s1_rty_i(s1_rty_i)
    );

    task automatic set_idle();
        rst_i     = 1'b0;
        m_addr_i  = 32'h0;
        m_data_i  = 32'h0;
        m_sel_i   = 4'h0;
        m_cyc_i   = 1'b0;
        m_stb_i   = 1'b0;
        m_we_i    = 1'b0;
        s0_data_i = 32'h0;
        s1_data_i = 32'h0;
        {s0_ack_i, s0_err_i, s0_rty_i} = 3'b000;
        {s1_ack_i, s1_err_i, s1_rty_i} = 3'b000;
    endtask

    task automatic test_reset();
        set_idle();
        rst_i = 1'b1; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        {s0_ack_i, s0_err_i, s0_rty_i} = 3'b111;
        {s1_ack_i, s1_err_i, s1_rty_i} = 3'b111;
        #1;
        checks++;
        if ({s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o} !== 4'b0000)
            $display("FAIL reset_cyc_stb got %b want 0000", {s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o});
        else passed++;
        checks++;
        if ({m_ack_o, m_err_o, m_rty_o} !== 3'b000)
            $display("FAIL reset_resp got %b want 000", {m_ack_o, m_err_o, m_rty_o});
        else passed++;
        m_addr_i = 32'h8000_0000; #1;
        checks++;
        if ({s1_cyc_o, s1_stb_o, m_ack_o, m_err_o, m_rty_o} !== 5'b00000)
            $display("FAIL reset_s1 got %b want 00000", {s1_cyc_o, s1_stb_o, m_ack_o, m_err_o, m_rty_o});
        else passed++;
        @(posedge clk_i); #1;
    endtask

    task automatic test_read_s0();
        set_idle();
        m_addr_i = 32'h0000_0010; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        s0_data_i = 32'hDEAD_BEEF; s1_data_i = 32'h1234_5678; s0_ack_i = 1'b1;
        #1;
        checks++;
        if ({s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o} !== 4'b1100)
            $display("FAIL read_strobes got %b want 1100", {s0_cyc_o, s0_stb_o, s1_cyc_o, s1_stb_o});
        else passed++;
        checks++;
        if (s0_addr_o !== 31'h10) $display("FAIL read_addr got %h want 00000010", s0_addr_o);
        else passed++;
        checks++;
        if (m_data_o !== 32'hDEAD_BEEF) $display("FAIL read_data got %h want deadbeef", m_data_o);
        else passed++;
        checks++;
        if (m_ack_o !== 1'b1) $display("FAIL read_ack got %b want 1", m_ack_o);
        else passed++;
    endtask

    task automatic test_write_s1();
        set_idle();
        m_addr_i = 32'h8000_0004; m_data_i = 32'h41; m_sel_i = 4'b0001;
        m_we_i = 1'b1; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        #1;
        checks++;
        if ({s0_stb_o, s1_cyc_o, s1_stb_o, s1_we_o} !== 4'b0111)
            $display("FAIL write_ctrl got %b want 0111", {s0_stb_o, s1_cyc_o, s1_stb_o, s1_we_o});
        else passed++;
        checks++;
        if ({s1_addr_o, s1_data_o, s1_sel_o} !== {31'h4, 32'h41, 4'b0001})
            $display("FAIL write_fields got %h/%h/%b want 00000004/00000041/0001", s1_addr_o, s1_data_o, s1_sel_o);
        else passed++;
        checks++;
        if (m_ack_o !== 1'b0) $display("FAIL write_ack_wait got %b want 0", m_ack_o);
        else passed++;
        s1_ack_i = 1'b1; #1;
        checks++;
        if (m_ack_o !== 1'b1) $display("FAIL write_ack got %b want 1", m_ack_o);
        else passed++;
        m_stb_i = 1'b0; #1;
        checks++;
        if ({m_ack_o, s1_stb_o} !== 2'b00) $display("FAIL ack_gated_by_stb got %b want 00", {m_ack_o, s1_stb_o});
        else passed++;
    endtask

    task automatic test_stray_and_simultaneous();
        set_idle();
        m_addr_i = 32'h0000_0000; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        {s1_ack_i, s1_err_i, s1_rty_i} = 3'b111;
        s1_data_i = 32'hCAFE_F00D; s0_data_i = 32'h0BAD_0BAD;
        #1;
        checks++;
        if ({m_ack_o, m_err_o, m_rty_o} !== 3'b000)
            $display("FAIL stray_resp got %b want 000", {m_ack_o, m_err_o, m_rty_o});
        else passed++;
        checks++;
        if (m_data_o !== 32'h0BAD_0BAD) $display("FAIL stray_data got %h want 0bad0bad", m_data_o);
        else passed++;
        s0_ack_i = 1'b1; #1;
        checks++;
        if ({m_ack_o, m_err_o, m_rty_o} !== 3'b100)
            $display("FAIL simul_resp got %b want 100", {m_ack_o, m_err_o, m_rty_o});
        else passed++;
    endtask

    task automatic test_err_rty();
        set_idle();
        m_addr_i = 32'h0000_0100; m_cyc_i = 1'b1; m_stb_i = 1'b1; s0_err_i = 1'b1;
        #1;
        checks++;
        if ({m_ack_o, m_err_o, m_rty_o} !== 3'b010)
            $display("FAIL s0_err got %b want 010", {m_ack_o, m_err_o, m_rty_o});
        else passed++;
        s0_err_i = 1'b0; s0_rty_i = 1'b1; #1;
        checks++;
        if ({m_ack_o, m_err_o, m_rty_o} !== 3'b001)
            $display("FAIL s0_rty got %b want 001", {m_ack_o, m_err_o, m_rty_o});
        else passed++;
        s0_rty_i = 1'b0; m_addr_i = 32'h8000_0100; s1_err_i = 1'b1; #1;
        checks++;
        if ({m_ack_o, m_err_o, m_rty_o} !== 3'b010)
            $display("FAIL s1_err got %b want 010", {m_ack_o, m_err_o, m_rty_o});
        else passed++;
    endtask

    task automatic test_boundary();
        set_idle();
        m_cyc_i = 1'b1; m_stb_i = 1'b1;
        s0_data_i = 32'h1111_1111; s1_data_i = 32'h2222_2222;
        m_addr_i = 32'h7FFF_FFFC; #1;
        checks++;
        if ({s0_stb_o, s1_stb_o, s0_addr_o, m_data_o} !== {1'b1, 1'b0, 31'h7FFF_FFFC, 32'h1111_1111})
            $display("FAIL bound_low got %b%b/%h/%h want 10/7ffffffc/11111111", s0_stb_o, s1_stb_o, s0_addr_o, m_data_o);
        else passed++;
        m_addr_i = 32'h8000_0000; #1;
        checks++;
        if ({s0_stb_o, s1_stb_o, s1_addr_o, m_data_o} !== {1'b0, 1'b1, 31'h0, 32'h2222_2222})
            $display("FAIL bound_high got %b%b/%h/%h want 01/00000000/22222222", s0_stb_o, s1_stb_o, s1_addr_o, m_data_o);
        else passed++;
    endtask

    task automatic test_reset_midcycle();
        set_idle();
        m_addr_i = 32'h0000_0020; m_cyc_i = 1'b1; m_stb_i = 1'b1; s0_ack_i = 1'b1;
        #1;
        checks++;
        if (m_ack_o !== 1'b1) $display("FAIL midcyc_pre_ack got %b want 1", m_ack_o);
        else passed++;
        rst_i = 1'b1; #1;
        checks++;
        if ({m_ack_o, s0_cyc_o, s0_stb_o} !== 3'b000)
            $display("FAIL midcyc_abort got %b want 000", {m_ack_o, s0_cyc_o, s0_stb_o});
        else passed++;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        set_idle();
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; m_addr_i = 32'h8000_0008; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        #1;
        checks++;
        if ({m_err_o, s1_stb_o} !== 2'b01) $display("FAIL wd_start got %b want 01", {m_err_o, s1_stb_o});
        else passed++;
        for (int rnd = 0; rnd < 2; rnd++) begin
            for (int k = 1; k <= 8; k++) begin
                @(posedge clk_i); #1;
                checks++;
                if (k < 8) begin
                    if ({m_err_o, s1_cyc_o, s1_stb_o} !== 3'b011)
                        $display("FAIL wd_stall r%0d k%0d got %b want 011", rnd, k, {m_err_o, s1_cyc_o, s1_stb_o});
                    else passed++;
                end else begin
                    if ({m_err_o, s1_cyc_o, s1_stb_o} !== 3'b100)
                        $display("FAIL wd_fire r%0d got %b want 100", rnd, {m_err_o, s1_cyc_o, s1_stb_o});
                    else passed++;
                end
            end
            @(posedge clk_i); #1;
            checks++;
            if ({m_err_o, s1_stb_o} !== 2'b01) $display("FAIL wd_restart r%0d got %b want 01", rnd, {m_err_o, s1_stb_o});
            else passed++;
        end
        m_stb_i = 1'b0;
        @(posedge clk_i); #1;
    endtask
`else
    task automatic test_timeout();
        set_idle();
        m_addr_i = 32'h8000_0008; m_cyc_i = 1'b1; m_stb_i = 1'b1;
        for (int k = 0; k < 20; k++) @(posedge clk_i);
        #1;
        checks++;
        if ({m_err_o, m_ack_o, s1_stb_o} !== 3'b001)
            $display("FAIL stall_forever got %b want 001", {m_err_o, m_ack_o, s1_stb_o});
        else passed++;
        m_stb_i = 1'b0;
    endtask
`endif

    initial begin
        set_idle();
        @(posedge clk_i); #1;
        test_reset();
        test_read_s0();
        test_write_s1();
        test_stray_and_simultaneous();
        test_err_rty();
        test_boundary();
        test_reset_midcycle();
        test_timeout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
